answer_submitter: RTL and testbench

ANSWER_SUBMITTER -- requirements
Module: answer_submitter

---
 rtl/answer_submitter.sv | 150 +++++++++++++++
 tb/tb_answer_submitter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/answer_submitter.sv
// answer_submitter: debounces the GO push-button and walks a game of
// NUM_LEVELS answers. Each answer is captured from the switches by a key
// press or by a timer expiry, then offered to the game controller with a
// valid/ready handshake.
module answer_submitter #(
  parameter int DB_CYCLES  = 1000000,
  parameter int NUM_LEVELS = 9
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        key_go_n,
  input  logic [11:0] sw,
  input  logic        time_up,
  input  logic        ans_ready,
  output logic        ans_valid,
  output logic [11:0] ans_data,
  output logic [3:0]  ans_level,
  output logic        ans_timeout,
  output logic        busy,
  output logic        done
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DB_CYCLES - 1);
  localparam logic [3:0]       LAST_LEVEL = 4'(NUM_LEVELS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SEND    = 2'd2,
    DONE    = 2'd3
  } state_t;

  logic             sync1_r;
  logic             sync2_r;
  logic             stable_r;
  logic [CNT_W-1:0] cnt_r;
  logic             press_evt_r;

  state_t      state_r;
  state_t      state_s;
  logic [11:0] data_s;
  logic [3:0]  level_s;
  logic        timeout_s;

  // Synchronize the raw key, debounce it, and pulse press_evt on a settled 1->0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_r     <= 1'b1;
      sync2_r     <= 1'b1;
      stable_r    <= 1'b1;
      cnt_r       <= '0;
      press_evt_r <= 1'b0;
    end else begin
      sync1_r <= key_go_n;
      sync2_r <= sync1_r;
      if (sync2_r == stable_r) begin
        cnt_r       <= '0;
        press_evt_r <= 1'b0;
      end else if (cnt_r == CNT_MAX) begin
        cnt_r       <= '0;
        stable_r    <= ~stable_r;
        // Only a settled press (stable going 1 -> 0) is an event; release is silent.
        press_evt_r <= stable_r;
      end else begin
        cnt_r       <= cnt_r + CNT_W'(1);
        press_evt_r <= 1'b0;
      end
    end
  end

  // Next-state and next-answer logic; outputs are registered from these values.
  always_comb begin
    state_s   = state_r;
    data_s    = ans_data;
    level_s   = ans_level;
    timeout_s = ans_timeout;
    case (state_r)
      IDLE: begin
        if (press_evt_r) begin
          state_s = COLLECT;
          level_s = 4'd1;
        end else begin
          state_s = IDLE;
        end
      end
      COLLECT: begin
        // A press beats a simultaneous timer expiry.
        if (press_evt_r) begin
          data_s    = sw;
          timeout_s = 1'b0;
          state_s   = SEND;
        end else if (time_up) begin
          data_s    = sw;
          timeout_s = 1'b1;
          state_s   = SEND;
        end else begin
          state_s = COLLECT;
        end
      end
      SEND: begin
        // Presses and timer pulses here are dropped; only the handshake matters.
        if (ans_ready) begin
          if (ans_level < LAST_LEVEL) begin
            level_s = ans_level + 4'd1;
            state_s = COLLECT;
          end else begin
            state_s = DONE;
          end
        end else begin
          state_s = SEND;
        end
      end
      DONE: begin
        if (press_evt_r) begin
          state_s = IDLE;
          level_s = 4'd1;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
        level_s = 4'd1;
      end
    endcase
  end

  // State and registered outputs; ans_valid never depends combinationally on ans_ready.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= IDLE;
      ans_data    <= 12'd0;
      ans_level   <= 4'd1;
      ans_timeout <= 1'b0;
      ans_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_r     <= state_s;
      ans_data    <= data_s;
      ans_level   <= level_s;
      ans_timeout <= timeout_s;
      ans_valid   <= (state_s == SEND);
      busy        <= (state_s == COLLECT) || (state_s == SEND);
      done        <= (state_s == DONE);
    end
  end

endmodule

// File: tb/tb_answer_submitter.sv
// Directed bench for answer_submitter with DB_CYCLES = 4, NUM_LEVELS = 3.
module tb_answer_submitter;

  logic        clk;
  logic        resetn;
  logic        key_go_n;
  logic [11:0] sw;
  logic        time_up;
  logic        ans_ready;
  logic        ans_valid;
  logic [11:0] ans_data;
  logic [3:0]  ans_level;
  logic        ans_timeout;
  logic        busy;
  logic        done;

  int total;
  int bad;
  int k;

  answer_submitter #(.DB_CYCLES(4), .NUM_LEVELS(3)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .key_go_n    (key_go_n),
    .sw          (sw),
    .time_up     (time_up),
    .ans_ready   (ans_ready),
    .ans_valid   (ans_valid),
    .ans_data    (ans_data),
    .ans_level   (ans_level),
    .ans_timeout (ans_timeout),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Clean press: the event fires 6 cycles after key goes low, release is debounced too.
  task automatic press();
    key_go_n = 1'b0;
    step(8);
    key_go_n = 1'b1;
    step(8);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    resetn    = 1'b0;
    key_go_n  = 1'b1;
    sw        = 12'h000;
    time_up   = 1'b0;
    ans_ready = 1'b0;
    step(2);
    chk("rst_valid", 32'(ans_valid), 32'd0);
    chk("rst_data", 32'(ans_data), 32'h000);
    chk("rst_level", 32'(ans_level), 32'd1);
    chk("rst_busy_done", 32'({busy, done, ans_timeout}), 32'd0);
    resetn = 1'b1;
    step(2);

    // Bounce: low 2, high 1, then low; event 6 cycles after final fall -> busy one later.
    key_go_n = 1'b0;
    step(2);
    key_go_n = 1'b1;
    step(1);
    key_go_n = 1'b0;
    k = 21;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (busy && k == 21) k = i;
    end
    chk("bounce_latency", 32'(k), 32'd7);
    chk("bounce_level", 32'(ans_level), 32'd1);
    chk("bounce_valid", 32'(ans_valid), 32'd0);
    key_go_n = 1'b1;
    step(10);
    chk("release_no_evt", 32'({busy, ans_valid}), 32'b10);

    // Normal game, three levels.
    sw = 12'h002;
    press();
    chk("l1_valid", 32'(ans_valid), 32'd1);
    chk("l1_data", 32'(ans_data), 32'h002);
    chk("l1_level", 32'(ans_level), 32'd1);
    chk("l1_timeout", 32'(ans_timeout), 32'd0);
    ans_ready = 1'b1;
    step(1);
    ans_ready = 1'b0;
    chk("l1_after_xfer", 32'({ans_valid, busy, ans_level}), 32'({1'b0, 1'b1, 4'd2}));
    sw = 12'h005;
    press();
    chk("l2_data", 32'(ans_data), 32'h005);
    chk("l2_level", 32'({ans_valid, ans_level}), 32'({1'b1, 4'd2}));
    ans_ready = 1'b1;
    step(1);
    ans_ready = 1'b0;
    sw = 12'h027;
    press();
    chk("l3_data", 32'(ans_data), 32'h027);
    chk("l3_level", 32'({ans_valid, ans_level}), 32'({1'b1, 4'd3}));
    ans_ready = 1'b1;
    step(1);
    ans_ready = 1'b0;
    chk("end_done_busy", 32'({done, busy, ans_valid}), 32'b100);
    chk("end_level_hold", 32'(ans_level), 32'd3);
    time_up = 1'b1;
    step(1);
    time_up = 1'b0;
    step(1);
    chk("done_ignores_tu", 32'({done, busy}), 32'b10);
    press();
    chk("done_to_idle", 32'({done, busy, ans_level}), 32'({1'b0, 1'b0, 4'd1}));
    time_up = 1'b1;
    step(1);
    time_up = 1'b0;
    step(1);
    chk("idle_ignores_tu", 32'({busy, ans_valid}), 32'd0);

    // Second game: ready while not valid, timeout capture, backpressure.
    press();
    chk("g2_collect", 32'({busy, ans_level}), 32'({1'b1, 4'd1}));
    ans_ready = 1'b1;
    step(3);
    ans_ready = 1'b0;
    chk("ready_no_effect", 32'({ans_valid, ans_level}), 32'({1'b0, 4'd1}));
    sw = 12'h088;
    time_up = 1'b1;
    step(1);
    time_up = 1'b0;
    chk("to_valid", 32'(ans_valid), 32'd1);
    chk("to_data", 32'(ans_data), 32'h088);
    chk("to_flag", 32'(ans_timeout), 32'd1);
    sw = 12'h0FF;
    press();
    time_up = 1'b1;
    step(1);
    time_up = 1'b0;
    chk("bp_hold", 32'({ans_valid, ans_data, ans_level}), 32'({1'b1, 12'h088, 4'd1}));
    ans_ready = 1'b1;
    step(1);
    ans_ready = 1'b0;
    step(3);
    chk("bp_one_xfer", 32'({ans_valid, busy, ans_level}), 32'({1'b0, 1'b1, 4'd2}));

    // Press event and time_up in the same COLLECT cycle: press wins.
    sw = 12'h123;
    key_go_n = 1'b0;
    step(6);
    time_up = 1'b1;
    step(1);
    time_up = 1'b0;
    chk("sim_valid_data", 32'({ans_valid, ans_data}), 32'({1'b1, 12'h123}));
    chk("sim_timeout", 32'(ans_timeout), 32'd0);
    key_go_n = 1'b1;
    step(8);
    chk("sim_still_send", 32'({ans_valid, ans_level}), 32'({1'b1, 4'd2}));

    // Asynchronous reset while offering an answer with ready high.
    ans_ready = 1'b1;
    resetn = 1'b0;
    #1;
    chk("arst_outputs", 32'({ans_valid, busy, done, ans_timeout}), 32'd0);
    chk("arst_data_level", 32'({ans_data, ans_level}), 32'({12'h000, 4'd1}));
    step(2);
    ans_ready = 1'b0;
    resetn = 1'b1;
    step(3);
    chk("post_rst_idle", 32'({busy, ans_valid, ans_level}), 32'({1'b0, 1'b0, 4'd1}));
    press();
    chk("fresh_press", 32'({busy, ans_valid, ans_level}), 32'({1'b1, 1'b0, 4'd1}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
